axi_gran_burst_merger_resp: RTL

- Response-side counterpart of the granular burst splitter.
- Merges the B and R responses of split sub-bursts back into one response stream per original upstream burst.
- B: emits exactly one upstream B per original write burst, with sticky error accumulation.
- R: forwards every beat and asserts upstream `last` only on the final beat of the original burst.
- Sits between the downstream (split) port and the upstream port; it queries the per-ID remaining-length counters allocated by the Ax-side splitter.

---
 rtl/axi_gran_pkg.sv | 47 ++++
 rtl/axi_gran_resp_reg.sv | 43 ++++
 rtl/axi_gran_burst_merger_resp.sv | 128 ++++++++++++
 3 files changed

// File: rtl/axi_gran_pkg.sv
// Shared types and helpers for the granular burst splitter / merger pair.
// Remaining-length values are AXI len encoded (beats - 1).
package axi_gran_pkg;

    typedef logic [8:0] num_beats_t;

    localparam int unsigned DefIdWidth = 4;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExOkay = 2'b01;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef struct packed {
        logic [DefIdWidth-1:0] id;
        logic [1:0]            resp;
        logic                  user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [DefIdWidth-1:0] id;
        logic [31:0]           data;
        logic [1:0]            resp;
        logic                  last;
        logic                  user;
    } axi_r_chan_t;

    typedef enum logic {
        BIdle,
        BHold
    } b_state_e;

    function automatic num_beats_t max_beats(input logic [7:0] len_limit);
        return {1'b0, len_limit} + 9'd1;
    endfunction

    // The looked-up sub-burst is the final one when its remaining beats fit in one split.
    function automatic logic is_last_sub(input logic [7:0] cnt_len, input logic [7:0] limit);
        return ({1'b0, cnt_len} + 9'd1) <= max_beats(limit);
    endfunction

    function automatic logic [1:0] merge_resp(input logic [1:0] resp, input logic sticky_err);
        if (resp[1]) return resp;
        return sticky_err ? RespSlvErr : resp;
    endfunction

endpackage

// File: rtl/axi_gran_resp_reg.sv
// One-entry valid/ready output register; accepts a new entry in the cycle the old one drains.
module axi_gran_resp_reg #(
    parameter type data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  valid_i,
    output logic  ready_o,
    input  data_t data_i,
    output logic  valid_o,
    input  logic  ready_i,
    output data_t data_o
);

    logic  valid_q, valid_d;
    data_t data_q, data_d;

    assign ready_o = rst_ni && (!valid_q || ready_i);
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_i && ready_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axi_gran_burst_merger_resp.sv
// Merges split-burst B/R responses back into one upstream response stream per original
// burst, using the per-ID remaining-length counters kept by the Ax-side splitter.
module axi_gran_burst_merger_resp
    import axi_gran_pkg::*;
#(
    parameter int unsigned IdWidth  = DefIdWidth,
    parameter type         id_t     = logic [IdWidth-1:0],
    parameter type         b_chan_t = axi_b_chan_t,
    parameter type         r_chan_t = axi_r_chan_t
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] len_limit_i,
    input  b_chan_t    b_i,
    input  logic       b_valid_i,
    output logic       b_ready_o,
    output b_chan_t    b_o,
    output logic       b_valid_o,
    input  logic       b_ready_i,
    input  r_chan_t    r_i,
    input  logic       r_valid_i,
    output logic       r_ready_o,
    output r_chan_t    r_o,
    output logic       r_valid_o,
    input  logic       r_ready_i,
    output id_t        w_cnt_id_o,
    input  logic [7:0] w_cnt_len_i,
    output logic       w_cnt_set_err_o,
    input  logic       w_cnt_err_i,
    output logic       w_cnt_dec_o,
    output logic       w_cnt_req_o,
    input  logic       w_cnt_gnt_i,
    output id_t        r_cnt_id_o,
    input  logic [7:0] r_cnt_len_i,
    output logic       r_cnt_dec_o,
    output logic       r_cnt_req_o,
    input  logic       r_cnt_gnt_i
);

    b_state_e b_state_q, b_state_d;
    b_chan_t  b_q, b_d;

    assign b_valid_o = (b_state_q == BHold);
    assign b_o       = b_q;

    always_comb begin
        b_state_d       = b_state_q;
        b_d             = b_q;
        b_ready_o       = 1'b0;
        w_cnt_req_o     = 1'b0;
        w_cnt_id_o      = '0;
        w_cnt_dec_o     = 1'b0;
        w_cnt_set_err_o = 1'b0;
        case (b_state_q)
            BIdle: begin
                if (b_valid_i) begin
                    w_cnt_req_o = 1'b1;
                    w_cnt_id_o  = b_i.id;
                    if (w_cnt_gnt_i) begin
                        b_ready_o   = 1'b1;
                        w_cnt_dec_o = 1'b1;
                        if (is_last_sub(w_cnt_len_i, len_limit_i)) begin
                            b_d       = b_i;
                            b_d.resp  = merge_resp(b_i.resp, w_cnt_err_i);
                            b_state_d = BHold;
                        end else begin
                            // Intermediate B is swallowed; its error survives in the counter.
                            w_cnt_set_err_o = b_i.resp[1];
                        end
                    end
                end
            end
            BHold: begin
                if (b_ready_i) b_state_d = BIdle;
            end
            default: b_state_d = BIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_state_q <= BIdle;
            b_q       <= '0;
        end else begin
            b_state_q <= b_state_d;
            b_q       <= b_d;
        end
    end

    // Only beats closing a downstream sub-burst need the counter to decide on upstream last.
    logic    r_sub_last;
    logic    r_reg_ready;
    logic    r_reg_valid;
    r_chan_t r_fwd;

    assign r_sub_last  = r_valid_i && r_i.last;
    assign r_cnt_req_o = r_sub_last;
    assign r_cnt_id_o  = r_sub_last ? r_i.id : '0;
    assign r_reg_valid = r_valid_i && (!r_i.last || r_cnt_gnt_i);
    assign r_ready_o   = r_reg_ready && (!r_sub_last || r_cnt_gnt_i);
    assign r_cnt_dec_o = r_sub_last && r_cnt_gnt_i && r_reg_ready;

    always_comb begin
        r_fwd      = r_i;
        r_fwd.last = r_i.last && is_last_sub(r_cnt_len_i, len_limit_i);
    end

    axi_gran_resp_reg #(
        .data_t (r_chan_t)
    ) i_r_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (r_reg_valid),
        .ready_o (r_reg_ready),
        .data_i  (r_fwd),
        .valid_o (r_valid_o),
        .ready_i (r_ready_i),
        .data_o  (r_o)
    );

    a_limit_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (b_valid_i || r_valid_i) |-> $stable(len_limit_i));
    a_b_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (b_valid_o && !b_ready_i) |=> $stable(b_o));
    a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid_o && !r_ready_i) |=> $stable(r_o));

endmodule
